mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// Responder end of the datapath memory interface: arbitrates the instruction-fetch
// and data (load/store) requests from the pipeline onto one single-ported RAM and
// returns the ihit/dhit pulses that advance or stall the pipeline registers.
// Data requests have priority; every response is registered and lasts one cycle.
// PARAMETERS
// ADDR_W    32  byte address width
// DATA_W    32  word width
// WAIT_MAX  15  max cycles in an access state without ram_ready before timeout
// PORTS
// CLK        in   1       clock, rising edge
// nRST       in   1       asynchronous active-low reset
// iREN       in   1       instruction fetch request, held until ihit
// iaddr      in   ADDR_W  fetch address
// dREN       in   1       data load request, held until dhit
// dWEN       in   1       data store request, held until dhit (dREN&dWEN illegal)
// daddr      in   ADDR_W  data address
// dstore     in   DATA_W  store data
// ihit       out  1       one-cycle fetch complete, iload valid same cycle
// dhit       out  1       one-cycle data complete, dload valid same cycle (loads)
// iload      out  DATA_W  fetched instruction (registered)
// dload      out  DATA_W  loaded data (registered)
// ramREN     out  1       RAM read strobe
// ramWEN     out  1       RAM write strobe
// ramaddr    out  ADDR_W  RAM address
// ramstore   out  DATA_W  RAM write data
// ramload    in   DATA_W  RAM read data, valid when ram_ready
// ram_ready  in   1       RAM completes current access this cycle
// mem_err    out  1       sticky timeout flag
// BEHAVIOUR
// - States IDLE, IACC, DACC, IRESP, DRESP. Reset: IDLE; all outputs 0, wait cnt 0.
// - IDLE: dREN|dWEN -> DACC (addr/data latched); else iREN -> IACC; else stay.
// - IACC/DACC drive ramREN/ramWEN/ramaddr/ramstore from latched values only;
//   all RAM outputs 0 in other states. Wait counter increments each ACC cycle.
// - ACC & ram_ready: latch ramload into iload/dload (not on store) -> IRESP/DRESP.
// - IRESP/DRESP: ihit/dhit high exactly this cycle, then IDLE. ihit&dhit never both.
// - Latency: request seen at edge 0, ready at first ACC cycle -> hit in cycle 2.
// - Back-to-back: after RESP, IDLE always spends one cycle; a still-pending data
//   request wins over fetch (fetch waits while pipeline does a load/store).
// - Request dropped mid-ACC (flush deasserts iREN): finish at ram_ready, discard,
//   no hit, return IDLE. RAM access is never cut short.
// - Timeout: cnt reaches WAIT_MAX without ready -> strobes drop, mem_err set
//   (sticky until reset), no hit, IDLE.
// - Reset mid-access: strobes fall asynchronously with nRST; no hit follows.
// - iload/dload hold their last value between hits.
// CONFIGURATION
// MEM_ARB_PERF_EN defined: adds outputs perf_ihits, perf_dhits, perf_stalls
//   (32 bits each, saturating at all-ones, reset 0): counts of ihit pulses, dhit
//   pulses, and cycles in IACC/DACC with ram_ready low.
// Undefined: those ports and counters do not exist; behaviour otherwise identical.
// TESTING
// - Reset mid-DACC: nRST low -> ramREN/ramWEN 0 immediately, state IDLE, no dhit.
// - iREN, iaddr=0x40, ram_ready after 3 cycles, ramload=0x8C220004 -> ihit one
//   cycle, iload=0x8C220004, ramaddr=0x40 during IACC.
// - iREN and dREN same cycle, daddr=0x100 -> DACC first, dhit, then IACC, ihit;
//   never simultaneous.
// - dWEN daddr=0x200 dstore=0xDEADBEEF -> ramWEN=1, ramstore=0xDEADBEEF; dhit,
//   dload unchanged.
// - iREN dropped during IACC -> access completes, no ihit, IDLE next.
// - ram_ready held 0 for 15 ACC cycles -> strobes 0, mem_err=1 until reset;
//   with MEM_ARB_PERF_EN, perf_stalls=15.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   This block is the responder end of the datapath memory interface. It takes
//   instruction-fetch and data (load/store) requests from the pipeline and puts
//   them onto one single-ported RAM. Data requests take priority over fetches.
//   For each completed access it returns a one-cycle registered ihit/dhit pulse,
//   which advances or stalls the pipeline.
//
// Parameters
//   ADDR_W    byte address width
//   DATA_W    word width
//   WAIT_MAX  maximum cycles in an access state without ram_ready before the
//             access is abandoned and mem_err is set
//
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   iREN, iaddr          fetch request (held until ihit) and address
//   dREN, dWEN           load / store request (held until dhit, never both)
//   daddr, dstore        data address and store data
//   ihit, iload          fetch complete pulse, fetched word
//   dhit, dload          data complete pulse, loaded word
//   ramREN, ramWEN       RAM read / write strobes
//   ramaddr, ramstore    RAM address and write data
//   ramload, ram_ready   RAM read data and access-complete
//   mem_err              sticky timeout flag
//
// Optional feature (macro MEM_ARB_PERF_EN)
//   Adds perf_ihits, perf_dhits and perf_stalls. These are saturating 32-bit
//   counters that count ihit pulses, dhit pulses, and access cycles spent
//   waiting on ram_ready. When the macro is undefined, these ports do not exist.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              mem_err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_ihits,
  output logic [31:0]       perf_dhits,
  output logic [31:0]       perf_stalls
`endif
);

  // state | meaning
  // ------+--------------------------------------------------------------
  // IDLE  | no access; picks data over fetch when deciding the next one
  // IACC  | fetch on the RAM, waiting for ram_ready
  // DACC  | load/store on the RAM, waiting for ram_ready
  // IRESP | ihit pulse cycle, iload holds the fetched word
  // DRESP | dhit pulse cycle, dload holds the loaded word (loads only)
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IACC  = 3'd1,
    DACC  = 3'd2,
    IRESP = 3'd3,
    DRESP = 3'd4
  } state_t;

  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  state_t              state, nstate;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   store_q;
  logic                wen_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                drop_q;
  logic [DATA_W-1:0]   iload_q, dload_q;
  logic                ihit_q, dhit_q;
  logic                err_q;

  logic                cap_i, cap_d;
  logic                acc;
  logic                req_held;
  logic                keep;
  logic                cnt_at_max;
  logic                timeout;

  assign cnt_at_max = (cnt_q == CNT_W'(WAIT_MAX - 1));

  always_comb begin
    nstate   = state;
    cap_i    = 1'b0;
    cap_d    = 1'b0;
    acc      = 1'b0;
    req_held = 1'b0;
    keep     = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (dREN || dWEN) begin
          nstate = DACC;
          cap_d  = 1'b1;
        end else if (iREN) begin
          nstate = IACC;
          cap_i  = 1'b1;
        end
      end
      IACC, DACC: begin
        acc      = 1'b1;
        req_held = (state == IACC) ? iREN : (dREN || dWEN);
        // A request that went away at any point during the access (pipeline
        // flush) still lets the RAM finish, but its result is thrown away.
        keep     = req_held && !drop_q;
        if (ram_ready) begin
          if (keep) nstate = (state == IACC) ? IRESP : DRESP;
          else      nstate = IDLE;
        end else if (cnt_at_max) begin
          timeout = 1'b1;
          nstate  = IDLE;
        end
      end
      IRESP, DRESP: nstate = IDLE;
      default:      nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wen_q   <= 1'b0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= nstate;
      ihit_q <= (nstate == IRESP);
      dhit_q <= (nstate == DRESP);

      if (cap_d) begin
        addr_q  <= daddr;
        store_q <= dstore;
        wen_q   <= dWEN;
      end else if (cap_i) begin
        addr_q  <= iaddr;
        store_q <= '0;
        wen_q   <= 1'b0;
      end

      if (cap_d || cap_i) begin
        cnt_q  <= '0;
        drop_q <= 1'b0;
      end else if (acc) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (!req_held) drop_q <= 1'b1;
      end

      if (nstate == IRESP)               iload_q <= ramload;
      if (nstate == DRESP && !wen_q)     dload_q <= ramload;
      if (timeout)                       err_q   <= 1'b1;
    end
  end

  // The RAM-side outputs decode directly from the state register. This means
  // the strobes fall together with the asynchronous reset of the state.
  assign ramREN   = (state == IACC) || (state == DACC && !wen_q);
  assign ramWEN   = (state == DACC) && wen_q;
  assign ramaddr  = (state == IACC || state == DACC) ? addr_q : '0;
  assign ramstore = (state == DACC && wen_q) ? store_q : '0;

  assign ihit    = ihit_q;
  assign dhit    = dhit_q;
  assign iload   = iload_q;
  assign dload   = dload_q;
  assign mem_err = err_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] pih_q, pdh_q, pst_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pih_q <= '0;
      pdh_q <= '0;
      pst_q <= '0;
    end else begin
      if (ihit_q && (pih_q != '1))            pih_q <= pih_q + 32'd1;
      if (dhit_q && (pdh_q != '1))            pdh_q <= pdh_q + 32'd1;
      if (acc && !ram_ready && (pst_q != '1)) pst_q <= pst_q + 32'd1;
    end
  end

  assign perf_ihits  = pih_q;
  assign perf_dhits  = pdh_q;
  assign perf_stalls = pst_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   This bench plays both the pipeline and the RAM. For each transaction the
//   expected per-cycle timeline comes from the request/response rules:
//     - A lone request is accepted at the first edge.
//     - ACC lasts (delay+1) cycles.
//     - The hit arrives one cycle after ready.
//     - When a fetch is queued behind data, it starts two cycles after dhit.
//   Expected data comes from an associative-array memory model.
//   Define MEM_ARB_PERF_EN to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ram_ready;
  logic        mem_err;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_ihits, perf_dhits, perf_stalls;
`endif

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(15)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .mem_err(mem_err)
`ifdef MEM_ARB_PERF_EN
    , .perf_ihits(perf_ihits), .perf_dhits(perf_dhits), .perf_stalls(perf_stalls)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_iload, exp_dload;
  logic        exp_err;
  int          exp_ihits, exp_dhits, exp_stalls;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_model();
    exp_iload  = '0;
    exp_dload  = '0;
    exp_err    = 1'b0;
    exp_ihits  = 0;
    exp_dhits  = 0;
    exp_stalls = 0;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, ".ramREN"}, 32'(ramREN), 32'd0);
    check_val({tag, ".ramWEN"}, 32'(ramWEN), 32'd0);
    check_val({tag, ".ramaddr"}, ramaddr, 32'd0);
    check_val({tag, ".ihit"}, 32'(ihit), 32'd0);
    check_val({tag, ".dhit"}, 32'(dhit), 32'd0);
    check_val({tag, ".iload"}, iload, exp_iload);
    check_val({tag, ".dload"}, dload, exp_dload);
    check_val({tag, ".mem_err"}, 32'(mem_err), 32'(exp_err));
  endtask

  // One transaction: optional data request (load or store) and optional fetch,
  // both presented in cycle 0. The RAM answers after dd / di waiting cycles.
  task automatic run_txn(input string tag, input bit do_i, input bit do_d, input bit d_wr,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                         input int di, input int dd);
    int d_start, d_ready, d_hit, i_start, i_ready, i_hit, last;
    bit in_i, in_d;
    d_start = -1; d_ready = -1; d_hit = -1;
    i_start = -1; i_ready = -1; i_hit = -1;
    if (do_d) begin
      d_start = 1; d_ready = 1 + dd; d_hit = 2 + dd;
    end
    if (do_i) begin
      i_start = do_d ? d_hit + 2 : 1;
      i_ready = i_start + di;
      i_hit   = i_ready + 1;
    end
    last = do_i ? i_hit : d_hit;
    for (int t = 0; t <= last + 1; t++) begin
      iREN   = do_i && (t <= i_hit);
      iaddr  = ia;
      dREN   = do_d && !d_wr && (t <= d_hit);
      dWEN   = do_d && d_wr && (t <= d_hit);
      daddr  = da;
      dstore = ds;
      in_d = do_d && (t >= d_start) && (t <= d_ready);
      in_i = do_i && (t >= i_start) && (t <= i_ready);
      ram_ready = (in_d && t == d_ready) || (in_i && t == i_ready);
      ramload   = in_d ? mem_rd(da) : (in_i ? mem_rd(ia) : 32'h0BAD0BAD);
      if ((in_d || in_i) && !ram_ready) exp_stalls++;

      check_val({tag, ".ramREN"}, 32'(ramREN), 32'(in_i || (in_d && !d_wr)));
      check_val({tag, ".ramWEN"}, 32'(ramWEN), 32'(in_d && d_wr));
      check_val({tag, ".ramaddr"}, ramaddr, in_d ? da : (in_i ? ia : 32'd0));
      check_val({tag, ".ramstore"}, ramstore, (in_d && d_wr) ? ds : 32'd0);
      check_val({tag, ".ihit"}, 32'(ihit), 32'(do_i && t == i_hit));
      check_val({tag, ".dhit"}, 32'(dhit), 32'(do_d && t == d_hit));
      check_val({tag, ".iload"}, iload, exp_iload);
      check_val({tag, ".dload"}, dload, exp_dload);
      check_val({tag, ".mem_err"}, 32'(mem_err), 32'(exp_err));

      if (do_i && t == i_hit) exp_ihits++;
      if (do_d && t == d_hit) exp_dhits++;
      if (in_d && t == d_ready) begin
        if (d_wr) mem[da] = ds;
        else      exp_dload = mem_rd(da);
      end
      if (in_i && t == i_ready) exp_iload = mem_rd(ia);
      step();
    end
    idle_inputs();
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic check_perf(input string tag);
    check_val({tag, ".perf_ihits"}, perf_ihits, 32'(exp_ihits));
    check_val({tag, ".perf_dhits"}, perf_dhits, 32'(exp_dhits));
    check_val({tag, ".perf_stalls"}, perf_stalls, 32'(exp_stalls));
  endtask
`endif

  initial begin
    idle_inputs();
    clear_model();
    nRST = 1'b0;
    #12;
    check_quiet("reset");
    check_val("reset.ramstore", ramstore, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    step();

    // Timeout: a load that never sees ram_ready gets WAIT_MAX access cycles.
    daddr = 32'h300;
    for (int t = 0; t <= 19; t++) begin
      dREN = (t <= 15);
      ram_ready = 1'b0;
      if (t >= 1 && t <= 15) exp_stalls++;
      if (t == 16) exp_err = 1'b1;
      check_val("timeout.ramREN", 32'(ramREN), 32'(t >= 1 && t <= 15));
      check_val("timeout.ramaddr", ramaddr, (t >= 1 && t <= 15) ? 32'h300 : 32'd0);
      check_val("timeout.dhit", 32'(dhit), 32'd0);
      check_val("timeout.mem_err", 32'(mem_err), 32'(exp_err));
      step();
    end
    idle_inputs();
`ifdef MEM_ARB_PERF_EN
    check_val("timeout.perf_stalls_15", perf_stalls, 32'd15);
`endif

    // Fetch from 0x40 with the RAM ready after 3 waiting cycles.
    mem[32'h40] = 32'h8C220004;
    run_txn("fetch40", 1, 0, 0, 32'h40, 32'h0, 32'h0, 3, 0);
    check_val("fetch40.iload", iload, 32'h8C220004);

    // Fetch and load in the same cycle: the data is served first.
    run_txn("both100", 1, 1, 0, 32'h44, 32'h100, 32'h0, 1, 2);

    // Store: the RAM gets the write, and dload is left unchanged.
    run_txn("store200", 0, 1, 1, 32'h0, 32'h200, 32'hDEADBEEF, 0, 1);
    check_val("store200.mem", mem_rd(32'h200), 32'hDEADBEEF);
    run_txn("load200", 0, 1, 0, 32'h0, 32'h200, 32'h0, 0, 0);
    check_val("load200.dload", dload, 32'hDEADBEEF);

    // Flush: iREN is dropped during IACC. The access completes, no ihit follows,
    // and the state returns to IDLE.
    iaddr = 32'h80;
    for (int t = 0; t <= 7; t++) begin
      iREN = (t < 2);
      ram_ready = (t == 4);
      ramload = 32'h11112222;
      if (t >= 1 && t <= 3) exp_stalls++;
      check_val("flush.ramREN", 32'(ramREN), 32'(t >= 1 && t <= 4));
      check_val("flush.ihit", 32'(ihit), 32'd0);
      check_val("flush.iload", iload, exp_iload);
      step();
    end
    idle_inputs();
    run_txn("after_flush", 1, 0, 0, 32'h84, 32'h0, 32'h0, 0, 0);

    // Reset in the middle of a store access.
    daddr = 32'h180; dstore = 32'h12345678; dWEN = 1'b1;
    step();
    check_val("rstmid.ramWEN_before", 32'(ramWEN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check_val("rstmid.ramWEN", 32'(ramWEN), 32'd0);
    check_val("rstmid.ramREN", 32'(ramREN), 32'd0);
    check_val("rstmid.mem_err", 32'(mem_err), 32'd0);
    idle_inputs();
    clear_model();
    @(negedge CLK);
    nRST = 1'b1;
    step();
    for (int t = 0; t < 4; t++) begin
      check_quiet("rstmid.after");
      step();
    end

    // Random mix of fetch/load/store requests with varied RAM latency.
    for (int n = 0; n < 300; n++) begin
      int kind, di, dd;
      logic [31:0] ia, da, ds;
      kind = int'($urandom_range(0, 4));
      ia = 32'($urandom_range(0, 63)) << 2;
      da = 32'($urandom_range(0, 63)) << 2;
      ds = $urandom;
      di = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 4));
      dd = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 4));
      case (kind)
        0:       run_txn("rnd_fetch", 1, 0, 0, ia, da, ds, di, dd);
        1:       run_txn("rnd_load", 0, 1, 0, ia, da, ds, di, dd);
        2:       run_txn("rnd_store", 0, 1, 1, ia, da, ds, di, dd);
        3:       run_txn("rnd_fetch_load", 1, 1, 0, ia, da, ds, di, dd);
        default: run_txn("rnd_fetch_store", 1, 1, 1, ia, da, ds, di, dd);
      endcase
    end

`ifdef MEM_ARB_PERF_EN
    check_perf("final");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
